// File: rtl/ej32_rstack.sv
// Return stack for the eJ32 branching unit: top in a register, spill entries in mem[].
// Define EJ32_RS_GUARD_EN to block overflow/underflow and enable the ovf/udf/rd_err flags.
module ej32_rstack #(
    parameter int unsigned DSZ   = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned ISZ   = 8,
    localparam int unsigned PSZ  = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     op,
    input  logic [DSZ-1:0] din,
    input  logic           rd_req,
    input  logic [ISZ-1:0] rd_idx,
    output logic [DSZ-1:0] r,
    output logic           r_z,
    output logic           rd_valid,
    output logic [DSZ-1:0] rd_data,
    output logic [PSZ:0]   cnt,
    output logic           empty,
    output logic           full,
    output logic           ovf,
    output logic           udf,
    output logic           rd_err
);

    typedef enum logic [2:0] {
        OpNop  = 3'd0,
        OpPush = 3'd1,
        OpPop  = 3'd2,
        OpMove = 3'd3,
        OpDnxt = 3'd4
    } op_e;

    // Common width for comparing the read index against the occupancy count.
    localparam int unsigned CW = (ISZ > PSZ + 1) ? ISZ : PSZ + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ej32_rstack: DEPTH must be a power of 2 and >= 4");
    end

    logic [DSZ-1:0] mem [DEPTH];

    logic [DSZ-1:0] r_q, r_d;
    logic [PSZ-1:0] rp_q, rp_d;
    logic [PSZ:0]   cnt_q, cnt_d;
    logic           rd_valid_q;
    logic [DSZ-1:0] rd_data_q, rd_data_d;

    logic           do_push, do_pop, do_move, do_dec;
    logic           push_ok, pop_ok;
    logic [PSZ-1:0] rp_dec;
    logic [DSZ-1:0] pop_data;
    logic [PSZ-1:0] rd_addr;
    logic           rd_in_range;

    assign r_z   = (r_q == '0);
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PSZ + 1)'(DEPTH));

    assign rp_dec   = rp_q - PSZ'(1);
    assign pop_data = mem[rp_dec];

    // Op decode; DNXT turns into a pop once the loop counter has reached zero.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_move = 1'b0;
        do_dec  = 1'b0;
        case (op)
            OpPush:  do_push = 1'b1;
            OpPop:   do_pop  = 1'b1;
            OpMove:  do_move = 1'b1;
            OpDnxt: begin
                if (r_z) do_pop = 1'b1;
                else     do_dec = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef EJ32_RS_GUARD_EN
    assign push_ok = do_push & ~full;
    assign pop_ok  = do_pop & ~empty;
`else
    assign push_ok = do_push;
    assign pop_ok  = do_pop;
`endif

    always_comb begin
        r_d   = r_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            r_d   = din;
            rp_d  = rp_q + PSZ'(1);
            cnt_d = full ? cnt_q : cnt_q + (PSZ + 1)'(1);
        end else if (pop_ok) begin
            r_d   = pop_data;
            rp_d  = rp_dec;
            cnt_d = empty ? cnt_q : cnt_q - (PSZ + 1)'(1);
        end else if (do_move) begin
            r_d = din;
        end else if (do_dec) begin
            r_d = r_q - DSZ'(1);
        end
    end

    // Indexed read sees the pre-op state of this cycle.
    assign rd_addr     = rp_q - PSZ'(rd_idx);
    assign rd_in_range = CW'(rd_idx) < CW'(cnt_q);

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_req) begin
            if (!rd_in_range)        rd_data_d = '0;
            else if (rd_idx == '0)   rd_data_d = r_q;
            else                     rd_data_d = mem[rd_addr];
        end
    end

    // Storage has no reset so it can map onto LUT or block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[rp_q] <= r_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            r_q        <= r_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_req;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef EJ32_RS_GUARD_EN
    logic ovf_q, udf_q, rd_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_q | (do_push & full);
            udf_q    <= udf_q | (do_pop & empty);
            rd_err_q <= rd_req & ~rd_in_range;
        end
    end

    assign ovf    = ovf_q;
    assign udf    = udf_q;
    assign rd_err = rd_err_q & rd_valid_q;
`else
    assign ovf    = 1'b0;
    assign udf    = 1'b0;
    assign rd_err = 1'b0;
`endif

    assign r        = r_q;
    assign cnt      = cnt_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_ej32_rstack.sv
// Directed bench for ej32_rstack at DEPTH=4; expectations follow EJ32_RS_GUARD_EN.
module tb_ej32_rstack;

`ifdef EJ32_RS_GUARD_EN
    localparam logic Guard = 1'b1;
`else
    localparam logic Guard = 1'b0;
`endif

    localparam int unsigned DSZ   = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ISZ   = 8;
    localparam int unsigned PSZ   = $clog2(DEPTH);

    logic           clk;
    logic           rst;
    logic [2:0]     op;
    logic [DSZ-1:0] din;
    logic           rd_req;
    logic [ISZ-1:0] rd_idx;
    logic [DSZ-1:0] r;
    logic           r_z;
    logic           rd_valid;
    logic [DSZ-1:0] rd_data;
    logic [PSZ:0]   cnt;
    logic           empty;
    logic           full;
    logic           ovf;
    logic           udf;
    logic           rd_err;

    int checks   = 0;
    int failures = 0;

    ej32_rstack #(
        .DSZ   (DSZ),
        .DEPTH (DEPTH),
        .ISZ   (ISZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .din      (din),
        .rd_req   (rd_req),
        .rd_idx   (rd_idx),
        .r        (r),
        .r_z      (r_z),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .cnt      (cnt),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .udf      (udf),
        .rd_err   (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples sit 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] d);
        op  = o;
        din = d;
        step();
        op  = 3'd0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst    = 1'b1;
        op     = 3'd0;
        din    = '0;
        rd_req = 1'b0;
        rd_idx = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // 1: reset mid-stream aborts state and any read
        do_op(3'd1, 32'h55);
        do_op(3'd1, 32'h66);
        rd_req = 1'b1;
        rd_idx = 8'd0;
        step();
        #2 rst = 1'b1;
        #1;
        check_eq("t1_async_rd_valid", rd_valid, 0);
        check_eq("t1_async_r", r, 0);
        rd_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_eq("t1_r", r, 0);
        check_eq("t1_cnt", cnt, 0);
        check_eq("t1_empty", empty, 1);
        check_eq("t1_rd_valid", rd_valid, 0);
        check_eq("t1_rd_data", rd_data, 0);
        do_op(3'd1, 32'h11);
        do_op(3'd1, 32'h22);
        do_op(3'd1, 32'h33);
        check_eq("t1_push_r", r, 32'h33);
        check_eq("t1_push_cnt", cnt, 3);
        check_eq("t1_push_empty", empty, 0);
        check_eq("t1_push_full", full, 0);

        // 2: pops and move
        do_op(3'd2, 32'h0);
        check_eq("t2_pop1_r", r, 32'h22);
        do_op(3'd2, 32'h0);
        check_eq("t2_pop2_r", r, 32'h11);
        check_eq("t2_pop2_cnt", cnt, 1);
        do_op(3'd3, 32'hAB);
        check_eq("t2_move_r", r, 32'hAB);
        check_eq("t2_move_cnt", cnt, 1);

        // 3: donext loop
        do_op(3'd1, 32'd3);
        check_eq("t3_push_cnt", cnt, 2);
        check_eq("t3_rz_pre", r_z, 0);
        do_op(3'd4, 32'h0);
        check_eq("t3_dnxt1_r", r, 2);
        do_op(3'd4, 32'h0);
        check_eq("t3_dnxt2_r", r, 1);
        do_op(3'd4, 32'h0);
        check_eq("t3_dnxt3_r", r, 0);
        check_eq("t3_dnxt3_rz", r_z, 1);
        check_eq("t3_dnxt3_cnt", cnt, 2);
        do_op(3'd4, 32'h0);
        check_eq("t3_dnxt4_r", r, 32'hAB);
        check_eq("t3_dnxt4_cnt", cnt, 1);
        check_eq("t3_dnxt4_rz", r_z, 0);

        // 4: indexed read alongside a push, then back-to-back reads
        reset_pulse();
        do_op(3'd1, 32'h11);
        do_op(3'd1, 32'h22);
        do_op(3'd1, 32'h33);
        rd_req = 1'b1;
        rd_idx = 8'd2;
        do_op(3'd1, 32'h44);
        rd_idx = 8'd0;
        check_eq("t4_rd_valid", rd_valid, 1);
        check_eq("t4_rd_data", rd_data, 32'h11);
        check_eq("t4_r", r, 32'h44);
        check_eq("t4_cnt", cnt, 4);
        check_eq("t4_full", full, 1);
        step();
        rd_idx = 8'd3;
        check_eq("t4_b2b0_valid", rd_valid, 1);
        check_eq("t4_b2b0_data", rd_data, 32'h44);
        step();
        rd_idx = 8'd4;
        check_eq("t4_b2b3_valid", rd_valid, 1);
        check_eq("t4_b2b3_data", rd_data, 32'h11);
        check_eq("t4_b2b3_err", rd_err, 0);
        step();
        rd_req = 1'b0;
        check_eq("t4_b2b4_data", rd_data, 0);
        check_eq("t4_b2b4_err", rd_err, Guard);
        step();
        check_eq("t4_idle_valid", rd_valid, 0);
        check_eq("t4_idle_err", rd_err, 0);

        // 5: push past full, then pop x3
        reset_pulse();
        for (int i = 1; i <= 5; i++) do_op(3'd1, 32'(i));
        check_eq("t5_r", r, Guard ? 32'd4 : 32'd5);
        check_eq("t5_cnt", cnt, 4);
        check_eq("t5_ovf", ovf, Guard);
        for (int i = 0; i < 3; i++) do_op(3'd2, 32'h0);
        check_eq("t5_pop_r", r, Guard ? 32'd1 : 32'd2);
        check_eq("t5_pop_cnt", cnt, 1);

        // 6: empty stack read and pop
        reset_pulse();
        check_eq("t6_ovf_clr", ovf, 0);
        rd_req = 1'b1;
        rd_idx = 8'd0;
        step();
        rd_req = 1'b0;
        check_eq("t6_rd_valid", rd_valid, 1);
        check_eq("t6_rd_data", rd_data, 0);
        check_eq("t6_rd_err", rd_err, Guard);
        do_op(3'd2, 32'h0);
        check_eq("t6_udf", udf, Guard);
        check_eq("t6_cnt", cnt, 0);
        check_eq("t6_empty", empty, 1);
        check_eq("t6_r", r, Guard ? 32'd0 : 32'd3);
        do_op(3'd7, 32'h99);
        check_eq("t6_nop7_r", r, Guard ? 32'd0 : 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
